// File: rtl/uart_tx_periph_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS layout, serializer state encoding and the 8N1 frame shape.
package uart_tx_periph_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_DONE      = 4;
  localparam int STAT_COUNT_LSB = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 8N1: one start bit, eight data bits LSB first, one stop bit
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 1 + DATA_BITS + 1;
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

  // A divisor of zero is treated as one cycle per bit
  function automatic logic [15:0] baud_load(input logic [15:0] div);
    if (div == 16'd0) begin
      return 16'd0;
    end else begin
      return div - 16'd1;
    end
  endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable. Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign count     = wr_ptr_r - rd_ptr_r;
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (count == (AW+1)'(DEPTH));
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage and pointer update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, serializer
// FSM and the transmit-complete level interrupt.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   div_r;
  logic          en_r;
  logic          ie_r;
  logic          ovf_r;
  logic          done_r;
  tx_state_e     state_r;
  logic [15:0]   baud_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;

  logic          wr_data_s;
  logic          wr_status_s;
  logic          wr_div_s;
  logic          wr_ctrl_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] fifo_count_s;
  logic          pop_s;
  logic          done_set_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  // Addr is the word address, so its two LSBs are byte-address bits [3:2]
  assign wr_data_s   = WE && (Addr[1:0] == REG_DATA);
  assign wr_status_s = WE && (Addr[1:0] == REG_STATUS);
  assign wr_div_s    = WE && (Addr[1:0] == REG_DIV);
  assign wr_ctrl_s   = WE && (Addr[1:0] == REG_CTRL);

  assign pop_s      = (state_r == ST_IDLE) && en_r && !fifo_empty_s;
  assign done_set_s = (state_r == ST_STOP) && (baud_r == 16'd0) && fifo_empty_s;
  assign unused_s   = ^{Addr[29:2], Din[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data_s),
    .pop   (pop_s),
    .din   (Din[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Control/status registers; DONE set has priority over any clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r  <= 16'(DEFAULT_DIV);
      en_r   <= 1'b0;
      ie_r   <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (wr_div_s) begin
        div_r <= Din[15:0];
      end
      if (wr_ctrl_s) begin
        en_r <= Din[0];
        ie_r <= Din[1];
      end
      if (wr_data_s && fifo_full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s) begin
        ovf_r <= 1'b0;
      end
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (wr_status_s || wr_data_s) begin
        done_r <= 1'b0;
      end
    end
  end

  // Serializer FSM; the baud counter reloads from DIV at every bit boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            state_r <= ST_START;
            shift_r <= fifo_dout_s;
            baud_r  <= baud_load(div_r);
            tx_r    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_r == 16'd0) begin
            state_r   <= ST_DATA;
            baud_r    <= baud_load(div_r);
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[7:1]};
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_r == 16'd0) begin
            baud_r <= baud_load(div_r);
            if (bit_idx_r == DATA_LAST) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_r == 16'd0) begin
            state_r <= ST_IDLE;
          end else begin
            baud_r <= baud_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

  // Read mux
  always_comb begin
    rdata_s = 32'd0;
    case (Addr[1:0])
      REG_STATUS: begin
        rdata_s[STAT_FULL]              = fifo_full_s;
        rdata_s[STAT_EMPTY]             = fifo_empty_s;
        rdata_s[STAT_BUSY]              = (state_r != ST_IDLE);
        rdata_s[STAT_OVF]               = ovf_r;
        rdata_s[STAT_DONE]              = done_r;
        rdata_s[STAT_COUNT_LSB +: 3]    = 3'(fifo_count_s);
      end
      REG_DIV:  rdata_s[15:0] = div_r;
      REG_CTRL: rdata_s[1:0]  = {ie_r, en_r};
      default:  rdata_s       = 32'd0;
    endcase
  end

  assign Dout = rdata_s;
  assign IRQ  = ie_r & done_r;
  assign tx   = tx_r;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed self-checking bench for uart_tx_periph: reset, single frame,
// overflow, back-to-back frames, DIV=0 and mid-frame DIV/EN changes.
module tb_uart_tx_periph;
  import uart_tx_periph_pkg::*;

  logic        clk;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  int pass_cnt  = 0;
  int check_cnt = 0;

  uart_tx_periph #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .tx    (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected tx waveform, one entry per clock; bits with index < split use p_lo
  function automatic logic [127:0] frame_bits(input logic [7:0] d, input int p_lo,
                                              input int p_hi, input int split);
    logic [127:0] v;
    int k;
    logic b;
    v = '0;
    k = 0;
    for (int n = 0; n < FRAME_BITS; n++) begin
      if (n == 0) b = 1'b0;
      else if (n == FRAME_BITS - 1) b = 1'b1;
      else b = d[n-1];
      for (int c = 0; c < ((n < split) ? p_lo : p_hi); c++) begin
        v[k] = b;
        k++;
      end
    end
    return v;
  endfunction

  // All bus tasks start and end just after a falling edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'd0, a};
    #1;
    d = Dout;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic capture(input int n, output logic [127:0] txv, output logic [127:0] irqv);
    txv  = '0;
    irqv = '0;
    for (int i = 0; i < n; i++) begin
      txv[i]  = tx;
      irqv[i] = IRQ;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bit ok;
    wr(REG_CTRL, 32'd1);
    wr(REG_DATA, 32'h00);
    wr(REG_DATA, 32'h00);
    wait_start(20, ok);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_cnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx_async: got %b expected 1", tx); else pass_cnt++;
    check_cnt++;
    if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h2) $display("FAIL reset_status: got %h expected 00000002", r); else pass_cnt++;
    rd(REG_DIV, r);
    check_cnt++;
    if (r !== 32'd16) $display("FAIL reset_div: got %0d expected 16", r); else pass_cnt++;
    rd(REG_CTRL, r);
    check_cnt++;
    if (r !== 32'd0) $display("FAIL reset_ctrl: got %h expected 0", r); else pass_cnt++;
    check_cnt++;
    if (tx !== 1'b1) $display("FAIL reset_tx_idle: got %b expected 1", tx); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [31:0] r;
    logic [127:0] txv, irqv, exp;
    bit ok;
    wr(REG_DIV, 32'd4);
    wr(REG_CTRL, 32'd3);
    wr(REG_DATA, 32'hA5);
    wait_start(20, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL single_start: got %b expected 1", ok); else pass_cnt++;
    capture(40, txv, irqv);
    exp = frame_bits(8'hA5, 4, 4, FRAME_BITS);
    check_cnt++;
    if (txv !== exp) $display("FAIL single_tx: got %h expected %h", txv, exp); else pass_cnt++;
    check_cnt++;
    if (irqv !== 128'd0) $display("FAIL single_irq_early: got %h expected 0", irqv); else pass_cnt++;
    check_cnt++;
    if (IRQ !== 1'b1) $display("FAIL single_irq_done: got %b expected 1", IRQ); else pass_cnt++;
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h12) $display("FAIL single_status: got %h expected 00000012", r); else pass_cnt++;
    wr(REG_STATUS, 32'd0);
    check_cnt++;
    if (IRQ !== 1'b0) $display("FAIL single_irq_clear: got %b expected 0", IRQ); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [127:0] txv, irqv, exp;
    bit ok;
    wr(REG_CTRL, 32'd0);
    wr(REG_DIV, 32'd1);
    for (int k = 1; k <= 5; k++) wr(REG_DATA, {24'd0, 4'(k), 4'(k)});
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h89) $display("FAIL ovf_status: got %h expected 00000089", r); else pass_cnt++;
    wr(REG_CTRL, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      wait_start(30, ok);
      check_cnt++;
      if (ok !== 1'b1) $display("FAIL ovf_start%0d: got %b expected 1", k, ok); else pass_cnt++;
      capture(10, txv, irqv);
      exp = frame_bits({4'(k), 4'(k)}, 1, 1, FRAME_BITS);
      check_cnt++;
      if (txv !== exp) $display("FAIL ovf_frame%0d: got %h expected %h", k, txv, exp); else pass_cnt++;
    end
    wait_start(40, ok);
    check_cnt++;
    if (ok !== 1'b0) $display("FAIL ovf_fifth_sent: got %b expected 0", ok); else pass_cnt++;
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h1A) $display("FAIL ovf_status_after: got %h expected 0000001a", r); else pass_cnt++;
    wr(REG_STATUS, 32'd0);
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h2) $display("FAIL ovf_status_clear: got %h expected 00000002", r); else pass_cnt++;
    wr(REG_CTRL, 32'd0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] txv, irqv, exp, exp_irq;
    bit ok;
    wr(REG_DIV, 32'd2);
    wr(REG_DATA, 32'h01);
    wr(REG_DATA, 32'h80);
    wr(REG_CTRL, 32'd3);
    wait_start(20, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL b2b_start: got %b expected 1", ok); else pass_cnt++;
    capture(42, txv, irqv);
    exp = frame_bits(8'h01, 2, 2, FRAME_BITS) | (128'd1 << 20)
        | (frame_bits(8'h80, 2, 2, FRAME_BITS) << 21) | (128'd1 << 41);
    exp_irq = 128'd1 << 41;
    check_cnt++;
    if (txv !== exp) $display("FAIL b2b_tx: got %h expected %h", txv, exp); else pass_cnt++;
    check_cnt++;
    if (irqv !== exp_irq) $display("FAIL b2b_done: got %h expected %h", irqv, exp_irq); else pass_cnt++;
    wr(REG_STATUS, 32'd0);
    wr(REG_CTRL, 32'd0);
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    logic [127:0] txv, irqv, exp, exp_irq;
    bit ok;
    wr(REG_DIV, 32'd0);
    rd(REG_DIV, r);
    check_cnt++;
    if (r !== 32'd0) $display("FAIL div0_read: got %h expected 0", r); else pass_cnt++;
    wr(REG_DATA, 32'hFF);
    wr(REG_CTRL, 32'd3);
    wait_start(20, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL div0_start: got %b expected 1", ok); else pass_cnt++;
    capture(11, txv, irqv);
    exp     = frame_bits(8'hFF, 1, 1, FRAME_BITS) | (128'd1 << 10);
    exp_irq = 128'd1 << 10;
    check_cnt++;
    if (txv !== exp) $display("FAIL div0_tx: got %h expected %h", txv, exp); else pass_cnt++;
    check_cnt++;
    if (irqv !== exp_irq) $display("FAIL div0_done: got %h expected %h", irqv, exp_irq); else pass_cnt++;
    wr(REG_STATUS, 32'd0);
    wr(REG_CTRL, 32'd0);
  endtask

  task automatic test_mid_frame();
    logic [31:0] r;
    logic [127:0] txv, exp;
    bit ok;
    wr(REG_DIV, 32'd4);
    wr(REG_CTRL, 32'd1);
    wr(REG_DATA, 32'hC3);
    wait_start(20, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL mid_start: got %b expected 1", ok); else pass_cnt++;
    // DIV=8 written during the third cycle of data bit 3
    txv = '0;
    for (int i = 0; i < 60; i++) begin
      txv[i] = tx;
      if (i == 17) begin
        Addr = {28'd0, REG_DIV};
        Din  = 32'd8;
        WE   = 1'b1;
      end else begin
        WE = 1'b0;
      end
      @(negedge clk);
    end
    exp = frame_bits(8'hC3, 4, 8, 5);
    check_cnt++;
    if (txv !== exp) $display("FAIL mid_div_tx: got %h expected %h", txv, exp); else pass_cnt++;
    // First byte pops one cycle after its push, leaving two queued
    wr(REG_DATA, 32'h01);
    wr(REG_DATA, 32'h02);
    wr(REG_DATA, 32'h03);
    txv = '0;
    for (int i = 0; i < 79; i++) begin
      txv[i] = tx;
      if (i == 10) begin
        Addr = {28'd0, REG_CTRL};
        Din  = 32'd0;
        WE   = 1'b1;
      end else begin
        WE = 1'b0;
      end
      @(negedge clk);
    end
    exp = frame_bits(8'h01, 8, 8, FRAME_BITS) >> 1;
    check_cnt++;
    if (txv !== exp) $display("FAIL mid_en_tx: got %h expected %h", txv, exp); else pass_cnt++;
    wait_start(100, ok);
    check_cnt++;
    if (ok !== 1'b0) $display("FAIL mid_en_no_pop: got %b expected 0", ok); else pass_cnt++;
    rd(REG_STATUS, r);
    check_cnt++;
    if (r !== 32'h40) $display("FAIL mid_en_status: got %h expected 00000040", r); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Addr  = 30'd0;
    Din   = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_overflow();
    test_back_to_back();
    test_div_zero();
    test_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
